// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode encodings and LED drive constants shared by the front-panel controller
package led_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;
  localparam logic [7:0] LED_ALL_OFF = 8'hFF;
  localparam logic [7:0] LED_ALL_ON  = 8'h00;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: syncs and debounces pushbutton, pulses press_evt once per debounced rise seen after a real low (clock, reset, pushbutton -> press_evt)
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_330_000
) (
  input  logic clock,
  input  logic reset,
  input  logic pushbutton,
  output logic press_evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_ff, sync_vld;
  logic btn_sync, btn_db, db_q, armed;
  logic [CW-1:0] stable_cnt;
  assign btn_sync = sync_ff[1];
  assign press_evt = btn_db & ~db_q & armed;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff <= '0;
      sync_vld <= '0;
      btn_db <= 1'b0;
      db_q <= 1'b0;
      armed <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_ff <= {sync_ff[0], pushbutton};
      sync_vld <= {sync_vld[0], 1'b1};
      db_q <= btn_db;
      armed <= armed | (sync_vld[1] & ~btn_sync);
      if (btn_sync == btn_db) stable_cnt <= '0;
      else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_sync;
        stable_cnt <= '0;
      end else stable_cnt <= stable_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_mode_controller.sv
// led_mode_controller: four-mode LED bank controller (clock, reset, pushbutton, count_byte -> counter_enable, leds active-low)
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_330_000,
  parameter int TICK_DIV = 16_625_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pushbutton,
  input  logic [7:0] count_byte,
  output logic       counter_enable,
  output logic [7:0] leds
);
  localparam int PW = $clog2(TICK_DIV);
  mode_t mode;
  logic press_evt, tick, scan_up, blink_ph;
  logic [PW-1:0] presc;
  logic [2:0] scan_pos;
  logic [7:0] pattern;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock(clock),
    .reset(reset),
    .pushbutton(pushbutton),
    .press_evt(press_evt)
  );
  assign tick = presc == PW'(TICK_DIV - 1);
  always_comb
    pattern = (mode == MODE_SCAN) ? ~(8'd1 << scan_pos) :
              (mode == MODE_BLINK) ? (blink_ph ? LED_ALL_ON : LED_ALL_OFF) : count_byte;
  always_ff @(posedge clock) begin
    if (reset) begin
      mode <= MODE_COUNT;
      presc <= '0;
      scan_pos <= '0;
      scan_up <= 1'b1;
      blink_ph <= 1'b0;
      leds <= LED_ALL_OFF;
      counter_enable <= 1'b0;
    end else begin
      leds <= pattern;
      counter_enable <= mode != MODE_FREEZE;
      if (press_evt) begin
        mode <= mode_t'(mode + 2'd1);
        presc <= '0;
        scan_pos <= '0;
        scan_up <= 1'b1;
        blink_ph <= 1'b0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && mode == MODE_SCAN) begin
          scan_pos <= scan_up ? scan_pos + 3'd1 : scan_pos - 3'd1;
          if (scan_up && scan_pos == 3'd6) scan_up <= 1'b0;
          if (!scan_up && scan_pos == 3'd1) scan_up <= 1'b1;
        end
        if (tick && mode == MODE_BLINK) blink_ph <= ~blink_ph;
      end
    end
  end
endmodule

// File: tb/tb_led_mode_controller.sv
// tb_led_mode_controller: directed stimulus with a cycle model of the LED controller plus literal spot checks
module tb_led_mode_controller;
  localparam int DC = 4;
  localparam int TD = 3;
  localparam logic [7:0] SEQ [16] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                                      8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pushbutton = 1'b0;
  logic [7:0] count_byte = 8'h3C;
  logic [7:0] leds;
  logic counter_enable;
  int vectors = 0;
  int miscompares = 0;
  led_mode_controller #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
    .clock(clock),
    .reset(reset),
    .pushbutton(pushbutton),
    .count_byte(count_byte),
    .counter_enable(counter_enable),
    .leds(leds)
  );
  always #5 clock = ~clock;
  bit pbq[$];
  bit synq[$];
  bit m_ok = 1'b0;
  bit m_sync, m_real, m_db, m_db_prev, m_armed, m_press, m_flip;
  int m_mode, m_since;
  logic [7:0] e_leds;
  logic e_en;
  function automatic logic [7:0] exp_pattern(input int mode, input int n, input logic [7:0] cb);
    int p;
    p = n % 14;
    if (mode == 1) return ~(8'd1 << (p <= 7 ? p : 14 - p));
    if (mode == 2) return (n % 2 == 1) ? 8'h00 : 8'hFF;
    return cb;
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      pbq.delete();
      synq.delete();
      m_sync = 0;
      m_real = 0;
      m_db = 0;
      m_db_prev = 0;
      m_armed = 0;
      m_mode = 0;
      m_since = 0;
      e_leds = 8'hFF;
      e_en = 1'b0;
      m_ok = 1'b1;
    end else begin
      m_press = m_db && !m_db_prev && m_armed;
      e_leds = exp_pattern(m_mode, m_since / TD, count_byte);
      e_en = m_mode != 3;
      if (m_press) begin
        m_mode = (m_mode + 1) % 4;
        m_since = 0;
      end else m_since++;
      synq.push_back(m_sync);
      m_flip = synq.size() >= DC;
      for (int i = 0; i < DC; i++)
        if (m_flip && synq[synq.size() - 1 - i] == m_db) m_flip = 0;
      m_db_prev = m_db;
      if (m_flip) m_db = !m_db;
      m_armed = m_armed || (m_real && !m_sync);
      pbq.push_back(pushbutton);
      m_real = pbq.size() >= 2;
      m_sync = m_real ? pbq[pbq.size() - 2] : 1'b0;
      if (synq.size() > 2 * DC) void'(synq.pop_front());
      if (pbq.size() > 4) void'(pbq.pop_front());
    end
  end
  always @(negedge clock) begin
    if (m_ok) begin
      vectors++;
      if (leds !== e_leds || counter_enable !== e_en) begin
        miscompares++;
        $display("FAIL model t=%0t leds=%h en=%b required leds=%h en=%b", $time, leds, counter_enable, e_leds, e_en);
      end
    end
  end
  task automatic check(input string name, input logic [7:0] l, input logic e);
    vectors++;
    if (leds !== l || counter_enable !== e) begin
      miscompares++;
      $display("FAIL %s leds=%h en=%b required leds=%h en=%b", name, leds, counter_enable, l, e);
    end
  endtask
  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic wait_for(input string name, input logic [7:0] l, input logic e);
    int k = 0;
    while ((leds !== l || counter_enable !== e) && k < 60) begin
      @(negedge clock);
      k++;
    end
    check(name, l, e);
  endtask
  initial begin
    int k;
    pushbutton = 1'b1;
    reset = 1'b1;
    tick_n(2);
    check("reset_state", 8'hFF, 1'b0);
    reset = 1'b0;
    tick_n(15);
    check("held_through_reset", 8'h3C, 1'b1);
    pushbutton = 1'b0;
    tick_n(10);
    pushbutton = 1'b1;
    tick_n(3);
    pushbutton = 1'b0;
    tick_n(10);
    check("glitch_rejected", 8'h3C, 1'b1);
    pushbutton = 1'b1;
    tick_n(7);
    check("press_latency_before", 8'h3C, 1'b1);
    tick_n(1);
    check("scan_0", SEQ[0], 1'b1);
    for (int i = 1; i < 16; i++) begin
      tick_n(TD);
      check($sformatf("scan_%0d", i), SEQ[i], 1'b1);
    end
    pushbutton = 1'b0;
    tick_n(10);
    pushbutton = 1'b1;
    wait_for("blink_enter", 8'hFF, 1'b1);
    tick_n(TD);
    check("blink_on", 8'h00, 1'b1);
    tick_n(TD);
    check("blink_off", 8'hFF, 1'b1);
    tick_n(TD);
    check("blink_on2", 8'h00, 1'b1);
    pushbutton = 1'b0;
    count_byte = 8'hA5;
    tick_n(10);
    pushbutton = 1'b1;
    wait_for("freeze_enter", 8'hA5, 1'b0);
    count_byte = 8'h5A;
    tick_n(2);
    check("freeze_follows_byte", 8'h5A, 1'b0);
    pushbutton = 1'b0;
    tick_n(10);
    pushbutton = 1'b1;
    wait_for("wrap_to_count", 8'h5A, 1'b1);
    pushbutton = 1'b0;
    tick_n(10);
    pushbutton = 1'b1;
    wait_for("scan_reenter", 8'hFE, 1'b1);
    pushbutton = 1'b0;
    wait_for("scan_pos5", 8'hDF, 1'b1);
    reset = 1'b1;
    tick_n(1);
    check("reset_mid_scan", 8'hFF, 1'b0);
    tick_n(1);
    reset = 1'b0;
    tick_n(2);
    check("after_reset_count", 8'h5A, 1'b1);
    pushbutton = 1'b1;
    k = 0;
    while (leds === 8'h5A && k < 60) begin
      tick_n(1);
      k++;
    end
    check("scan_restart", 8'hFE, 1'b1);
    pushbutton = 1'b0;
    tick_n(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
